date_sequencer: RTL
===================

# date_sequencer

Sequencing controller for the calendar display path. It owns the day-of-year value (1..99) that feeds the day-to-month/day translator and the HEX drivers. It steps that value manually from a pushbutton or automatically from a prescaled tick, loads it from switches, wraps it at the ends of the range, and latches the leap-year selection so the translator never sees a leap change in the middle of a year.

## Interface
Parameters:
- TICK_DIV, 50_000_000: clock cycles per auto-advance step (1 Hz at 50 MHz); must be ≥2
- DEBOUNCE_CYCLES, 1_000_000: cycles the synchronized button must stay stable before a level is accepted; must be ≥1
- MAX_DAY, 99: upper bound of day-of-year; the 7-bit translator input limits it to 99

Ports:
- clk  in  1  single system clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- step_n  in  1  raw pushbutton, active-low, asynchronous, bouncing
- run  in  1  switch: 1 = auto-advance, 0 = manual
- dir  in  1  switch: 0 = count up, 1 = count down
- load_n  in  1  raw pushbutton, active-low: load load_value
- load_value  in  7  switch-set day to load
- leap_sw  in  1  raw leap-year switch
- number  out  7  day-of-year to the translator, always in 1..MAX_DAY
- leap  out  1  latched leap selection to the translator
- changed  out  1  one-cycle strobe, high in the first cycle that a new number is presented
- wrapped  out  1  one-cycle strobe, coincident with changed, when the update wrapped around
- state  out  2  current FSM state, for debug LEDs

## Operation
- Every asynchronous input (step_n, run, dir, load_n, leap_sw) passes through a 2-flop synchronizer. All behaviour below acts on the synchronized values.
- step_n is also debounced. Its debounced falling edge produces step_pulse, one cycle wide. load_n is used as a plain synchronized level.
- FSM states: MANUAL=0, AUTO=1, LOAD=2.
  - Any state → LOAD when load_n is low. LOAD has the highest priority.
  - LOAD: while load_n is low, hold LOAD. When load_n goes high, go to AUTO if run=1, otherwise MANUAL.
  - MANUAL → AUTO when run=1. AUTO → MANUAL when run=0.
- Prescaler:
  - Counts 0..TICK_DIV-1, and only in AUTO.
  - Cleared to 0 on every entry to AUTO and in every other state.
  - tick is asserted when the prescaler equals TICK_DIV-1. The prescaler returns to 0 on the following cycle.
- Advance events:
  - In MANUAL, step_pulse advances number.
  - In AUTO, tick advances number and step_pulse is ignored.
  - In LOAD, neither step_pulse nor tick has any effect.
- Advance arithmetic:
  - Up: number==MAX_DAY → 1, otherwise number+1.
  - Down: number==1 → MAX_DAY, otherwise number−1.
  - Either wrap also asserts wrapped.
- Load:
  - Every cycle in LOAD, number takes the clamped load_value: 0 → 1, values above MAX_DAY → MAX_DAY, all others pass unchanged.
  - changed pulses only in cycles where the clamped value differs from the current number.
- Leap latch: leap takes synchronized leap_sw on any cycle in which number is written with the value 1, and on every cycle in LOAD. leap_sw changes at any other time are ignored until the next year boundary or load.
- number never leaves 1..MAX_DAY, including immediately after reset.

## Timing
- Reset values: number=1, leap=0, changed=0, wrapped=0, state=MANUAL, prescaler=0, synchronizers and debouncer idle (button released).
- All outputs are registered. changed and wrapped rise in the same cycle as the new number.
- Button latency: the step_n press is accepted 2 sync cycles + DEBOUNCE_CYCLES after its falling edge. step_pulse follows in the next cycle, and number updates on the following edge.
- AUTO period: exactly TICK_DIV cycles between successive number updates. The first update comes TICK_DIV cycles after entering AUTO.
- step_pulse and an AUTO entry in the same cycle: the step is dropped.
- A reset assertion mid-count returns every register to its reset value immediately (asynchronous). Reset release is synchronous in effect: no update occurs on the first edge after release.

## Structure
- Shared package date_pkg holds:
  - MAX_DAY_DEFAULT=99
  - day_t as a 7-bit type
  - the state enum {MANUAL, AUTO, LOAD}
- The translator imports date_pkg for day_t.
- One sub-module, debounce_pulse: 2-flop synchronizer, stability counter (parameter DEBOUNCE_CYCLES) and falling-edge one-shot. It is instantiated for step_n.
- The FSM, prescaler, counter, clamp and leap latch live in date_sequencer.

## Test plan
Bench parameters: TICK_DIV=5, DEBOUNCE_CYCLES=4.
- Reset, then a clean step_n press in MANUAL with dir=0 → number 1→2, changed high for exactly 1 cycle, state=0.
- step_n bounce (low/high toggling every cycle for 3 cycles, then held low) → exactly one advance, after stability is reached.
- load_value=99, pulse load_n, then one step with dir=0 → number=99, then 1 with wrapped=1. With dir=1 at number=1, one step → 99 with wrapped=1.
- run=1 from number=58 → updates exactly every 5 cycles to 59, 60, 61. Presses during AUTO cause no extra advance. Setting run=0 freezes the count.
- leap_sw=1 set while number=40 → leap stays 0 until number wraps to 1 or a load occurs, then leap=1.
- load_value=0 → number=1. load_value=120 → number=99. Reset asserted during AUTO at number=70 → number=1, state=MANUAL, leap=0 at once.

Source files
------------

// File: rtl/date_pkg.sv
// Shared types and helpers for the calendar display path: day type, sequencer
// states and the load-value clamp.
package date_pkg;

   localparam int MAX_DAY_DEFAULT = 99;

   typedef logic [6:0] day_t;

   typedef enum logic [1:0] {
      MANUAL = 2'd0,
      AUTO   = 2'd1,
      LOAD   = 2'd2
   } state_t;

   // Forces a switch-set value into 1..max_day so the translator never sees 0.
   function automatic day_t clamp_day(input day_t value, input day_t max_day);
      if (value == day_t'(0)) begin
         return day_t'(1);
      end
      if (value > max_day) begin
         return max_day;
      end
      return value;
   endfunction

endpackage

// File: rtl/debounce_pulse.sv
// Synchronizes a bouncing active-low pushbutton, waits for a stable level and
// emits a one-cycle pulse on each accepted press.
module debounce_pulse #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_n,
   output logic pulse
);

   localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1_reg;
   logic          sync2_reg;
   logic          level_reg;
   logic          pulse_reg;
   logic [CW-1:0] cnt_reg;

   // The counter only runs while the synchronized input disagrees with the
   // accepted level; any return to the accepted level restarts the wait.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg <= 1'b1;
         sync2_reg <= 1'b1;
         level_reg <= 1'b1;
         pulse_reg <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         sync1_reg <= raw_n;
         sync2_reg <= sync1_reg;
         pulse_reg <= 1'b0;
         if (sync2_reg == level_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
            level_reg <= sync2_reg;
            cnt_reg   <= '0;
            pulse_reg <= ~sync2_reg;
         end else begin
            cnt_reg <= cnt_reg + CW'(1);
         end
      end
   end

   assign pulse = pulse_reg;

endmodule

// File: rtl/date_sequencer.sv
// Day-of-year sequencer: manual/auto stepping, switch load with clamp, range
// wrap and a leap latch that only changes at year boundaries or loads.
module date_sequencer
   import date_pkg::*;
#(
   parameter int TICK_DIV        = 50_000_000,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int MAX_DAY         = MAX_DAY_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       step_n,
   input  logic       run,
   input  logic       dir,
   input  logic       load_n,
   input  logic [6:0] load_value,
   input  logic       leap_sw,
   output logic [6:0] number,
   output logic       leap,
   output logic       changed,
   output logic       wrapped,
   output logic [1:0] state
);

   localparam day_t MAX_D = day_t'(MAX_DAY);
   localparam int   PW    = $clog2(TICK_DIV);
   // Bit order {leap_sw, load_n, dir, run}; load_n idles high.
   localparam logic [3:0] SYNC_IDLE = 4'b0100;

   logic [3:0]    sync1_reg;
   logic [3:0]    sync2_reg;
   logic          run_s;
   logic          dir_s;
   logic          load_s;
   logic          leap_s;
   logic          step_pulse;

   state_t        state_reg;
   logic [PW-1:0] presc_reg;
   day_t          number_reg;
   logic          leap_reg;
   logic          changed_reg;
   logic          wrapped_reg;

   logic          tick;
   logic          stay_auto;
   logic          step_adv;
   logic          adv;
   logic          adv_wrap;
   day_t          adv_val;
   day_t          load_val;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg <= SYNC_IDLE;
         sync2_reg <= SYNC_IDLE;
      end else begin
         sync1_reg <= {leap_sw, load_n, dir, run};
         sync2_reg <= sync1_reg;
      end
   end

   assign run_s  = sync2_reg[0];
   assign dir_s  = sync2_reg[1];
   assign load_s = sync2_reg[2];
   assign leap_s = sync2_reg[3];

   debounce_pulse #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_step_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .raw_n (step_n),
      .pulse (step_pulse)
   );

   always_comb begin
      tick      = (state_reg == AUTO) && (presc_reg == PW'(TICK_DIV - 1));
      stay_auto = (state_reg == AUTO) && load_s && run_s;
      // A step arriving as MANUAL hands over to AUTO or LOAD is dropped.
      step_adv  = (state_reg == MANUAL) && step_pulse && load_s && !run_s;
      adv       = step_adv || tick;
      if (dir_s) begin
         adv_wrap = (number_reg == day_t'(1));
         adv_val  = adv_wrap ? MAX_D : number_reg - day_t'(1);
      end else begin
         adv_wrap = (number_reg == MAX_D);
         adv_val  = adv_wrap ? day_t'(1) : number_reg + day_t'(1);
      end
      load_val  = clamp_day(load_value, MAX_D);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= MANUAL;
         presc_reg   <= '0;
         number_reg  <= day_t'(1);
         leap_reg    <= 1'b0;
         changed_reg <= 1'b0;
         wrapped_reg <= 1'b0;
      end else begin
         changed_reg <= 1'b0;
         wrapped_reg <= 1'b0;

         case (state_reg)
            MANUAL: begin
               if (!load_s)     state_reg <= LOAD;
               else if (run_s)  state_reg <= AUTO;
            end
            AUTO: begin
               if (!load_s)     state_reg <= LOAD;
               else if (!run_s) state_reg <= MANUAL;
            end
            LOAD: begin
               if (load_s)      state_reg <= run_s ? AUTO : MANUAL;
            end
            default: state_reg <= MANUAL;
         endcase

         // Held at zero outside AUTO so every AUTO entry starts a full period.
         if (stay_auto && !tick) begin
            presc_reg <= presc_reg + PW'(1);
         end else begin
            presc_reg <= '0;
         end

         if (state_reg == LOAD) begin
            leap_reg <= leap_s;
            if (load_val != number_reg) begin
               number_reg  <= load_val;
               changed_reg <= 1'b1;
            end
         end else if (adv) begin
            number_reg  <= adv_val;
            changed_reg <= 1'b1;
            wrapped_reg <= adv_wrap;
            if (adv_val == day_t'(1)) begin
               leap_reg <= leap_s;
            end
         end
      end
   end

   assign number  = number_reg;
   assign leap    = leap_reg;
   assign changed = changed_reg;
   assign wrapped = wrapped_reg;
   assign state   = state_reg;

endmodule
